tx_arbiter: RTL

Round-robin transmit scheduler that shares the single RMII Ethernet transmitter among `N_REQ` frame sources. It grants one requester at a time and forwards that requester's dibit stream, registered, to the transmitter's `axiiv`/`axiid` input. It waits for the transmitter to finish preamble, data and FCS, then enforces the 96-bit-time interpacket gap before the next grant. It also guards against requesters that stall and against oversize frames.

---
 rtl/tx_arb_pkg.sv | 25 ++
 rtl/rr_picker.sv | 34 +++
 rtl/tx_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and default constants for the RMII transmit arbiter.
// Contents: scheduler state enum, parameter defaults, pointer-width helper.
package tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STREAM,
        DRAIN,
        IPG
    } arb_state_t;

    // 96 bit times at 2 bits per clock.
    localparam int IPG_CYCLES_DEF    = 48;
    // 1518-byte maximum frame expressed in dibits.
    localparam int MAX_DIBITS_DEF    = 6072;
    localparam int START_TIMEOUT_DEF = 16;
    localparam int DRAIN_TIMEOUT_DEF = 8192;

    // Width of a requester index; never zero even for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Ports: req (request vector), ptr (highest-priority index),
//        pick (one-hot winner), any (at least one request).
module rr_picker
    import tx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [PTR_W-1:0] idx;

    // Scan offsets from farthest to nearest so the request closest to
    // ptr (wrapping) is the last one written and therefore wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one RMII transmitter among N_REQ sources.
// Ports: clk, rst (sync active-high); req/req_axiiv/req_axiid per-requester
//        request, valid and dibit; grant one-hot; tx_axiov/tx_axiod to the
//        transmitter; tether_axiov transmitter activity; busy, trunc_err,
//        timeout_err status.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int IPG_CYCLES    = IPG_CYCLES_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF,
    parameter int MAX_DIBITS    = MAX_DIBITS_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_axiiv,
    input  logic [2*N_REQ-1:0] req_axiid,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_axiov,
    output logic [1:0]         tx_axiod,
    input  logic               tether_axiov,
    output logic               busy,
    output logic               trunc_err,
    output logic               timeout_err
);

    localparam int PTR_W = ptr_width(N_REQ);
    localparam int ST_W  = $clog2(START_TIMEOUT + 1);
    localparam int DIB_W = $clog2(MAX_DIBITS + 1);
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int IPG_W = $clog2(IPG_CYCLES + 1);

    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_TIMEOUT - 1);
    localparam logic [DIB_W-1:0] DIB_MAX  = DIB_W'(MAX_DIBITS);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_CYCLES - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [ST_W-1:0]  start_cnt;
    logic [DIB_W-1:0] dibit_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [IPG_W-1:0] ipg_cnt;
    logic             seen_hi;

    logic [N_REQ-1:0] pick;
    logic             any;
    logic [PTR_W-1:0] next_ptr;
    logic             sel_req;
    logic             sel_valid;
    logic [1:0]       sel_data;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // Pointer moves one past the winner so the winner gets lowest
    // priority next time.
    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                next_ptr = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    // Registered grant selects the lane; other lanes never reach the
    // transmitter.
    always_comb begin
        sel_req   = |(req & grant);
        sel_valid = |(req_axiiv & grant);
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_axiid[2*i +: 2];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            tx_axiov    <= 1'b0;
            tx_axiod    <= 2'b00;
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;
            start_cnt   <= '0;
            dibit_cnt   <= '0;
            drain_cnt   <= '0;
            ipg_cnt     <= '0;
            seen_hi     <= 1'b0;
        end else begin
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;

            // Transmitter activity can start while we are still
            // streaming, so remember it from GRANT onward.
            if ((state == GRANT || state == STREAM || state == DRAIN)
                && tether_axiov) begin
                seen_hi <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant     <= pick;
                        ptr       <= next_ptr;
                        start_cnt <= '0;
                        dibit_cnt <= '0;
                        drain_cnt <= '0;
                        ipg_cnt   <= '0;
                        seen_hi   <= 1'b0;
                        state     <= GRANT;
                    end
                end

                GRANT: begin
                    if (sel_valid) begin
                        tx_axiov  <= 1'b1;
                        tx_axiod  <= sel_data;
                        dibit_cnt <= DIB_W'(1);
                        state     <= STREAM;
                    end else if (!sel_req) begin
                        // Requester withdrew; nothing was sent, no gap.
                        grant <= '0;
                        state <= IDLE;
                    end else if (start_cnt == ST_LAST) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        start_cnt <= start_cnt + ST_W'(1);
                    end
                end

                STREAM: begin
                    if (sel_valid && dibit_cnt < DIB_MAX) begin
                        tx_axiod  <= sel_data;
                        dibit_cnt <= dibit_cnt + DIB_W'(1);
                    end else begin
                        // Valid still high here means the frame hit the
                        // size limit and is being cut.
                        tx_axiov  <= 1'b0;
                        tx_axiod  <= 2'b00;
                        grant     <= '0;
                        drain_cnt <= '0;
                        trunc_err <= sel_valid;
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (seen_hi && !tether_axiov) begin
                        ipg_cnt <= '0;
                        state   <= IPG;
                    end else if (drain_cnt == DRN_LAST) begin
                        timeout_err <= 1'b1;
                        ipg_cnt     <= '0;
                        state       <= IPG;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end

                IPG: begin
                    if (ipg_cnt == IPG_LAST) begin
                        state <= IDLE;
                    end else begin
                        ipg_cnt <= ipg_cnt + IPG_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
